// File: rtl/tx_port_grant_arbiter.sv
// Per-output-port round-robin grant arbiter for the VOQ transmit chain.
// Holds a one-hot grant until the granted manager's done pulse arrives;
// a watchdog (frozen by keep_in) forces release of a grant that never completes.
module tx_port_grant_arbiter #(
   parameter int unsigned PORT_NUB = 8,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [PORT_NUB-1:0]                     req,
   input  logic [PORT_NUB-1:0]                     done,
   input  logic                                    keep_in,
   output logic [PORT_NUB-1:0]                     grant,
   output logic                                    grant_valid,
   output logic [((PORT_NUB > 1) ? $clog2(PORT_NUB) : 1)-1:0] grant_nub,
   output logic                                    timeout_err
);

   localparam int unsigned WIDTH_SEL = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1;
   localparam int unsigned WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [WIDTH_SEL-1:0] ptr_q, ptr_d;
   logic [WDOG_W-1:0]    wdog_q, wdog_d;
   logic [PORT_NUB-1:0]  grant_q, grant_d;
   logic                 grant_valid_q, grant_valid_d;
   logic [WIDTH_SEL-1:0] grant_nub_q, grant_nub_d;
   logic                 timeout_err_q, timeout_err_d;

   logic                 sel_found;
   logic [WIDTH_SEL-1:0] sel_idx;
   logic [WIDTH_SEL-1:0] nub_next;
   int unsigned          scan_idx;

   // Rotating-priority scan: first requester at or after ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < PORT_NUB; k++) begin
         scan_idx = 32'(ptr_q) + k;
         if (scan_idx >= PORT_NUB) begin
            scan_idx = scan_idx - PORT_NUB;
         end
         if (!sel_found && req[scan_idx[WIDTH_SEL-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx[WIDTH_SEL-1:0];
         end
      end
   end

   // Pointer value that moves priority just past the port being released.
   always_comb begin
      if (grant_nub_q == WIDTH_SEL'(PORT_NUB - 1)) begin
         nub_next = '0;
      end else begin
         nub_next = grant_nub_q + WIDTH_SEL'(1);
      end
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      wdog_d        = wdog_q;
      grant_d       = grant_q;
      grant_nub_d   = grant_nub_q;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!keep_in && sel_found) begin
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               grant_nub_d      = sel_idx;
               wdog_d           = '0;
               state_d          = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (done[grant_nub_q]) begin
               grant_d = '0;
               ptr_d   = nub_next;
               state_d = ST_IDLE;
            end else if (keep_in) begin
               wdog_d = wdog_q;
            end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
               grant_d       = '0;
               timeout_err_d = 1'b1;
               ptr_d         = nub_next;
               state_d       = ST_ERR;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         ST_ERR: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase

      grant_valid_d = |grant_d;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         wdog_q        <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_nub_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         wdog_q        <= wdog_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_nub_q   <= grant_nub_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_nub   = grant_nub_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tx_port_grant_arbiter.sv
// Bench for tx_port_grant_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural owner/pointer model.
module tb_tx_port_grant_arbiter;

   localparam int unsigned N  = 8;
   localparam int unsigned TO = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic         keep_in;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [2:0]   grant_nub;
   logic         timeout_err;

   int checks = 0;
   int errors = 0;

   // Model: who owns the port (-1 = nobody), last owner, priority pointer,
   // cycles spent un-stalled while owning, and the one-cycle error window.
   int m_owner, m_nub, m_ptr, m_age;
   bit m_err;

   tx_port_grant_arbiter #(.PORT_NUB(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .keep_in(keep_in),
      .grant(grant), .grant_valid(grant_valid), .grant_nub(grant_nub),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input int ptr, input logic [N-1:0] r);
      for (int k = 0; k < int'(N); k++) begin
         if (r[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs applied to the DUT.
   task automatic model_edge();
      if (!rst_n) begin
         m_owner = -1; m_nub = 0; m_ptr = 0; m_age = 0; m_err = 1'b0;
      end else if (m_err) begin
         m_err = 1'b0;
      end else if (m_owner < 0) begin
         if (!keep_in && req != '0) begin
            m_owner = pick(m_ptr, req);
            m_nub   = m_owner;
            m_age   = 0;
         end
      end else if (done[m_owner]) begin
         m_ptr   = (m_owner + 1) % int'(N);
         m_owner = -1;
      end else if (!keep_in) begin
         if (m_age == int'(TO) - 1) begin
            m_ptr   = (m_owner + 1) % int'(N);
            m_owner = -1;
            m_err   = 1'b1;
         end else begin
            m_age++;
         end
      end
   endtask

   // One clock: update model on the edge, then compare all outputs.
   task automatic step();
      logic [N-1:0] exp_grant;
      @(posedge clk);
      model_edge();
      #1;
      exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      check_eq("grant_nub", 32'(grant_nub), 32'(m_nub));
      check_eq("timeout_err", 32'(timeout_err), 32'(m_err));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; done = '0; keep_in = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      m_owner = -1; m_nub = 0; m_ptr = 0; m_age = 0; m_err = 1'b0;
      do_reset();

      // T1: reset while busy with port 5
      req = 8'h20;
      repeat (4) step();
      check_eq("t1_busy_nub", 32'(grant_nub), 32'd5);
      rst_n = 1'b0;
      repeat (3) step();
      check_eq("t1_rst_grant", 32'(grant), 32'd0);
      check_eq("t1_rst_nub", 32'(grant_nub), 32'd0);
      check_eq("t1_rst_err", 32'(timeout_err), 32'd0);
      rst_n = 1'b1; req = 8'h24;
      step();
      check_eq("t1_lowest", 32'(grant_nub), 32'd2);

      // T2: single requester, release and re-grant after one idle cycle
      do_reset();
      req = 8'h04;
      step();
      check_eq("t2_grant", 32'(grant), 32'h04);
      repeat (4) step();
      done = 8'h04;
      step();
      done = '0;
      check_eq("t2_release", 32'(grant), 32'h00);
      step();
      check_eq("t2_regrant", 32'(grant), 32'h04);

      // T3: all requesting, sequence 0..7,0
      do_reset();
      req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         n = 0;
         while (!grant_valid && n < 10) begin step(); n++; end
         check_eq("t3_nub", 32'(grant_nub), 32'(g % 8));
         repeat (2) step();
         done = N'(1) << grant_nub;
         step();
         done = '0;
      end

      // T4: wrap from 7 to 0, foreign done ignored
      do_reset();
      req = 8'h40;
      step();
      done = 8'h40; step(); done = '0;
      req = 8'h81;
      step();
      check_eq("t4_nub7", 32'(grant_nub), 32'd7);
      done = 8'h08; step(); step(); done = '0;
      check_eq("t4_hold7", 32'(grant), 32'h80);
      done = 8'h80; step(); done = '0;
      step();
      check_eq("t4_nub0", 32'(grant_nub), 32'd0);

      // T5: timeout 16 cycles after grant, then first requester >= 4
      do_reset();
      req = 8'h08;
      step();
      req = 8'h38;
      repeat (15) step();
      check_eq("t5_early_err", 32'(timeout_err), 32'd0);
      step();
      check_eq("t5_err", 32'(timeout_err), 32'd1);
      check_eq("t5_grant0", 32'(grant), 32'd0);
      repeat (2) step();
      check_eq("t5_next", 32'(grant_nub), 32'd4);

      // T6: stall blocks grant, delays watchdog, done still releases
      do_reset();
      keep_in = 1'b1; req = 8'h10;
      repeat (3) step();
      check_eq("t6_nogrant", 32'(grant_valid), 32'd0);
      keep_in = 1'b0;
      step();
      n = 0;
      keep_in = 1'b1;
      repeat (10) begin step(); n++; end
      keep_in = 1'b0;
      while (!timeout_err && n < 40) begin step(); n++; end
      check_eq("t6_shift", 32'(n), 32'd26);
      step(); step();
      keep_in = 1'b1; done = 8'h10;
      step();
      check_eq("t6_done_stall", 32'(grant), 32'd0);
      done = '0; keep_in = 1'b0;

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 299) != 0);
         req     = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : N'($urandom);
         done    = N'($urandom & $urandom & $urandom);
         keep_in = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
